uart_tx_frame: RTL
==================

# uart_tx_frame

Parametrised UART transmit framer, successor to the fixed 8N1 one-clock-per-bit transmitter. It serialises one word per valid/ready handshake, holds each bit for a programmable number of clocks, and supports 5–9 data bits, optional parity and 1 or 2 stop bits. It sits between the system-side byte source (FIFO or CPU register) and the TX pad.

## Interface
- CLKS_PER_BIT, default 16: clocks per serial bit; legal range ≥2.
- DATA_BITS, default 8: data bits per frame; legal range 5..9.
- STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
- clk, input, 1: clock.
- reset_n, input, 1: reset, asynchronous, active-low.
- i_tx_data, input, DATA_BITS: word to send.
- i_tx_valid, input, 1: word present.
- o_tx_ready, output, 1: block can accept a word. Registered.
- i_parity_mode, input, 2: 0 none, 1 even, 2 odd, 3 none. Latched with the data.
- o_tx_serial, output, 1: serial line. Registered; idles high (mark).
- o_tx_active, output, 1: high from the start bit through the last stop bit.
- o_tx_done, output, 1: single-cycle pulse when a frame completes.

## Operation
- FSM states: IDLE → START → DATA → PARITY → STOP → IDLE.
- IDLE:
  - o_tx_ready=1, o_tx_serial=1.
  - Acceptance requires i_tx_valid && o_tx_ready at a clock edge.
  - On that edge: latch i_tx_data and i_parity_mode; go to START; drive serial 0; set active=1; clear ready.
- After acceptance, input changes are ignored until the next acceptance.
- Bit timing: a cycle counter (0..CLKS_PER_BIT-1) advances the FSM. Each bit lasts exactly CLKS_PER_BIT cycles.
- DATA: bits are sent LSB first. The bit index runs 0..DATA_BITS-1 and wraps to 0 on leaving DATA.
- PARITY:
  - Entered only when the latched mode is 1 or 2; otherwise DATA goes directly to STOP.
  - Even mode sends ^data; odd mode sends ~^data.
- STOP: serial is 1 for STOP_BITS × CLKS_PER_BIT cycles.
- Last cycle of the final stop bit, on its edge: go to IDLE; pulse o_tx_done for one cycle; drop active to 0; set ready to 1.
- Frame length is (1 + DATA_BITS + P + STOP_BITS) × CLKS_PER_BIT cycles, where P=1 if parity is enabled, else 0.
- Reset values: serial=1, ready=0, active=0, done=0, state=IDLE, counters=0. Ready rises on the first clock edge after reset_n deasserts.
- Reset mid-frame:
  - The frame is abandoned; serial goes to 1 asynchronously.
  - No done pulse is generated, and no pending word is retained.
- Valid held high continuously: frames go out back-to-back with a 1-cycle mark gap, which is the IDLE cycle in which done=1 and ready=1.
- Valid while not ready: ignored. The source must hold it; no word is dropped silently.

## Timing
- Accept at edge N → start bit on o_tx_serial from edge N to edge N+CLKS_PER_BIT.
- Data bit k starts at edge N + (1+k)×CLKS_PER_BIT.
- o_tx_done is high for the cycle after edge N + frame length. It coincides with ready=1.
- o_tx_active rises at edge N and falls at edge N + frame length.
- Earliest next acceptance: edge N + frame length + 1.

## Configuration
- Macro: UART_TX_PARITY_EN.
  - Defined: the PARITY state and parity logic are compiled in, and i_parity_mode acts as described above.
  - Undefined: the port remains but is ignored; DATA always goes to STOP, and frame length uses P=0.

## Structure
- uart_pkg holds:
  - state encoding localparams (IDLE, START, DATA, PARITY, STOP);
  - parity mode constants (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2).
- Sub-module uart_baud_gen, parameter CLKS_PER_BIT:
  - a clear-able cycle counter;
  - a bit_end strobe in the last cycle of each bit;
  - cleared on acceptance.

## Test plan
- 8N1, CLKS_PER_BIT=4, data 0xA5, mode 0 → serial 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; done pulse once, 40 cycles after acceptance; active high for exactly 40 cycles.
- Macro defined, data 0x07: mode 1 gives parity bit 1, mode 2 gives parity bit 0, both with a 44-cycle frame. Macro undefined, mode 1 → 40-cycle frame with no parity bit.
- DATA_BITS=7, STOP_BITS=2, data 0x41 → start bit 0, then 1,0,0,0,0,0,1, then 8 cycles of 1; done after 40 cycles.
- Valid held high with data 0x55, then 0xAA → two frames separated by exactly 1 mark cycle. i_tx_data changed mid-frame → transmitted word unchanged.
- reset_n pulsed low during data bit 3 → serial=1 immediately; ready=0 during reset; no done pulse; ready=1 one edge after release; next frame correct.
- Valid asserted during STOP → not accepted until the IDLE cycle; ready stays 0 throughout the frame.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit framer:
//   - state_t          : framer FSM states (IDLE, START, DATA, PARITY, STOP)
//   - PAR_NONE/EVEN/ODD: parity mode codes carried on i_parity_mode
//   - parity_enabled() : true when a mode code asks for a parity bit
// Optional feature macro used by the framer: UART_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Mode 3 is a second spelling of "no parity", so only the two real
  // parity codes enable the extra bit.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
// Bit-period timer for the UART framer. Counts 0..CLKS_PER_BIT-1 while
// enabled and strobes o_bit_end during the last cycle of each bit.
// Ports:
//   clk       : clock
//   reset_n   : asynchronous active-low reset
//   i_clear   : synchronous clear, used when a new word is accepted
//   i_enable  : count while a frame is on the line
//   o_bit_end : high in the final cycle of the current bit
// Parameter CLKS_PER_BIT must be >= 2.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_bit_end
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  // The counter wraps on its own at the end of every bit, so each bit of
  // the frame gets exactly CLKS_PER_BIT cycles without any reload from
  // the FSM; the clear only guarantees a clean phase on acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign o_bit_end = i_enable && (r_count == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// Parametrised UART transmit framer: one word per valid/ready handshake,
// start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop
// bits, each bit held for CLKS_PER_BIT clocks.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   i_tx_data      : word to send (DATA_BITS wide), latched on acceptance
//   i_tx_valid     : word present
//   o_tx_ready     : registered, high only in IDLE once out of reset
//   i_parity_mode  : 0 none, 1 even, 2 odd, 3 none; latched with the data
//   o_tx_serial    : registered serial line, idles high
//   o_tx_active    : high from the start bit through the last stop bit
//   o_tx_done      : one-cycle pulse after the last stop bit
// Configuration macro: UART_TX_PARITY_EN. When undefined the parity bit is
// never sent and i_parity_mode is ignored.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  input  logic [1:0]           i_parity_mode,
  output logic                 o_tx_serial,
  output logic                 o_tx_active,
  output logic                 o_tx_done
);

  localparam int            IW        = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [DATA_BITS-1:0] r_data;
  logic [IW-1:0]        r_bit_idx;
  logic [IW-1:0]        w_bit_idx_next;
  logic [IW-1:0]        w_bit_idx_inc;
  logic                 r_stop_idx;
  logic                 w_stop_idx_next;
  logic                 r_serial;
  logic                 w_serial_next;
  logic                 r_ready;
  logic                 w_ready_next;
  logic                 r_active;
  logic                 w_active_next;
  logic                 r_done;
  logic                 w_done_next;
  logic                 w_accept;
  logic                 w_bit_end;
  logic                 w_parity_en;
  logic                 w_parity_bit;

  // Ready is only ever high in IDLE, so this is the whole acceptance rule.
  assign w_accept      = i_tx_valid && r_ready;
  assign w_bit_idx_inc = r_bit_idx + 1'b1;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_accept),
    .i_enable (r_state != IDLE),
    .o_bit_end(w_bit_end)
  );

`ifdef UART_TX_PARITY_EN
  logic [1:0] r_mode;

  // The parity mode travels with the word so a source may change it
  // mid-frame without corrupting the frame on the line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode <= PAR_NONE;
    end else if (w_accept) begin
      r_mode <= i_parity_mode;
    end
  end

  assign w_parity_en  = parity_enabled(r_mode);
  assign w_parity_bit = (r_mode == PAR_ODD) ? ~^r_data : ^r_data;
`else
  logic w_unused_parity_mode;

  assign w_unused_parity_mode = ^i_parity_mode;
  assign w_parity_en          = 1'b0;
  assign w_parity_bit         = 1'b0;
`endif

  // State register. Reset abandons any frame in flight, so no done pulse
  // and no retained word can survive it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic plus the next values of every registered output.
  // The serial line is computed one cycle ahead so that the bit value
  // lands on o_tx_serial exactly on the edge where the FSM enters the bit.
  always_comb begin
    w_next_state    = r_state;
    w_serial_next   = r_serial;
    w_ready_next    = r_ready;
    w_active_next   = r_active;
    w_done_next     = 1'b0;
    w_bit_idx_next  = r_bit_idx;
    w_stop_idx_next = r_stop_idx;

    case (r_state)
      IDLE: begin
        w_serial_next = 1'b1;
        w_active_next = 1'b0;
        if (w_accept) begin
          w_next_state  = START;
          w_serial_next = 1'b0;
          w_active_next = 1'b1;
          w_ready_next  = 1'b0;
        end else begin
          w_ready_next  = 1'b1;
        end
      end

      START: begin
        if (w_bit_end) begin
          w_next_state  = DATA;
          w_serial_next = r_data[0];
        end
      end

      DATA: begin
        if (w_bit_end) begin
          if (r_bit_idx == LAST_IDX) begin
            w_bit_idx_next = '0;
            if (w_parity_en) begin
              w_next_state  = PARITY;
              w_serial_next = w_parity_bit;
            end else begin
              w_next_state  = STOP;
              w_serial_next = 1'b1;
            end
          end else begin
            w_bit_idx_next = w_bit_idx_inc;
            w_serial_next  = r_data[w_bit_idx_inc];
          end
        end
      end

      PARITY: begin
        if (w_bit_end) begin
          w_next_state  = STOP;
          w_serial_next = 1'b1;
        end
      end

      STOP: begin
        if (w_bit_end) begin
          if (r_stop_idx == STOP_LAST) begin
            w_next_state    = IDLE;
            w_stop_idx_next = 1'b0;
            w_done_next     = 1'b1;
            w_active_next   = 1'b0;
            w_ready_next    = 1'b1;
          end else begin
            w_stop_idx_next = r_stop_idx + 1'b1;
          end
        end
      end

      default: begin
        w_next_state  = IDLE;
        w_serial_next = 1'b1;
      end
    endcase
  end

  // Datapath and output registers. The serial line resets to mark
  // asynchronously so the pad goes idle the moment reset is asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data     <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_serial   <= 1'b1;
      r_ready    <= 1'b0;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_data <= i_tx_data;
      end
      r_bit_idx  <= w_bit_idx_next;
      r_stop_idx <= w_stop_idx_next;
      r_serial   <= w_serial_next;
      r_ready    <= w_ready_next;
      r_active   <= w_active_next;
      r_done     <= w_done_next;
    end
  end

  assign o_tx_serial = r_serial;
  assign o_tx_ready  = r_ready;
  assign o_tx_active = r_active;
  assign o_tx_done   = r_done;

endmodule
